// File: rtl/hazard_stall_control_pkg.sv
// Shared definitions for the stall/bubble controller: instruction field
// positions, opcode and ALU-op constants, and the multdiv handshake FSM encoding.
package hazard_stall_control_pkg;

   // Instruction field bit positions
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RD_MSB  = 26;
   localparam int RD_LSB  = 22;
   localparam int RS_MSB  = 21;
   localparam int RS_LSB  = 17;
   localparam int RT_MSB  = 16;
   localparam int RT_LSB  = 12;
   localparam int ALU_MSB = 6;
   localparam int ALU_LSB = 2;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;

   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;

   localparam int BUSY_CNT_W = 6;

   typedef logic [4:0] reg_num_t;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_MD_BUSY = 1'b1
   } md_state_t;

endpackage

// File: rtl/hazard_stall_control_if.sv
// Pipeline-side bundle for the stall controller: the instruction registers and
// multdiv status going in, and the latch enables, bubbles and multdiv controls coming out.
interface hazard_stall_control_if;
   logic [31:0] FD_IR;
   logic [31:0] DX_IR;
   logic        multdiv_ready;
   logic        multdiv_exception;
   logic        pc_en;
   logic        fd_en;
   logic        dx_en;
   logic        dx_bubble;
   logic        xm_bubble;
   logic        ctrl_mult;
   logic        ctrl_div;
   logic        md_result_sel;
   logic        md_exception;
   logic        md_timeout;
   logic [31:0] stall_count;

   modport master (
      output FD_IR, DX_IR, multdiv_ready, multdiv_exception,
      input  pc_en, fd_en, dx_en, dx_bubble, xm_bubble, ctrl_mult, ctrl_div,
             md_result_sel, md_exception, md_timeout, stall_count
   );

   modport slave (
      input  FD_IR, DX_IR, multdiv_ready, multdiv_exception,
      output pc_en, fd_en, dx_en, dx_bubble, xm_bubble, ctrl_mult, ctrl_div,
             md_result_sel, md_exception, md_timeout, stall_count
   );
endinterface

// File: rtl/hazard_stall_control_src_decode.sv
// Maps an instruction to the registers it reads. Source A is always rs; source B
// is rt for R-type and rd for sw/bne/blt/jr. Register 0 never reports a use.
module hazard_src_decode
   import hazard_stall_control_pkg::*;
(
   input  logic [31:0] i_ir,
   output reg_num_t    o_src_a,
   output reg_num_t    o_src_b,
   output logic        o_use_a,
   output logic        o_use_b,
   output logic        o_is_sw
);

   logic [4:0] w_opcode;
   logic       w_unused_ir;

   assign w_opcode    = i_ir[OPC_MSB:OPC_LSB];
   assign w_unused_ir = ^i_ir[RT_LSB-1:0];

   always_comb begin
      // NOTE: every output is given a default first, so no decode path can infer a latch.
      o_src_a = i_ir[RS_MSB:RS_LSB];
      o_src_b = i_ir[RD_MSB:RD_LSB];
      o_use_a = 1'b0;
      o_use_b = 1'b0;
      o_is_sw = 1'b0;
      case (w_opcode)
         OP_RTYPE: begin
            o_use_a = 1'b1;
            o_use_b = 1'b1;
            o_src_b = i_ir[RT_MSB:RT_LSB];
         end
         OP_ADDI, OP_LW: o_use_a = 1'b1;
         OP_SW: begin
            o_use_a = 1'b1;
            o_use_b = 1'b1;
            o_is_sw = 1'b1;
         end
         OP_BNE, OP_BLT: begin
            o_use_a = 1'b1;
            o_use_b = 1'b1;
         end
         OP_JR:   o_use_b = 1'b1;
         default: ;
      endcase
      if (o_src_a == '0) o_use_a = 1'b0;
      if (o_src_b == '0) o_use_b = 1'b0;
   end

endmodule

// File: rtl/hazard_stall_control.sv
// Stall/bubble controller: load-use detection between FD and DX, start/wait
// handshake with the multdiv unit, and PC/FD/DX/XM latch enable generation.
module hazard_stall_control
   import hazard_stall_control_pkg::*;
#(
   parameter int TIMEOUT = 63
) (
   input  logic                   clock,
   input  logic                   reset,
   hazard_stall_control_if.slave  bus
);

   localparam logic [BUSY_CNT_W-1:0] TIMEOUT_CNT = BUSY_CNT_W'(TIMEOUT);

   md_state_t             r_state;
   md_state_t             w_next_state;
   logic [BUSY_CNT_W-1:0] r_busy_cnt;
   logic [31:0]           r_stall_count;

   reg_num_t   w_src_a, w_src_b, w_dx_rd;
   logic       w_use_a, w_use_b, w_fd_is_sw;
   logic [4:0] w_dx_opcode, w_dx_alu_op;
   logic       w_dx_is_mul, w_dx_is_div, w_dx_is_md, w_dx_is_lw;
   logic       w_match_a, w_match_b, w_load_use;
   logic       w_pc_en, w_fd_en, w_dx_en, w_dx_bubble, w_xm_bubble;
   logic       w_ctrl_mult, w_ctrl_div, w_md_result_sel, w_md_exception, w_md_timeout;
   logic       w_unused_dx;

   hazard_src_decode u_fd_decode (
      .i_ir    (bus.FD_IR),
      .o_src_a (w_src_a),
      .o_src_b (w_src_b),
      .o_use_a (w_use_a),
      .o_use_b (w_use_b),
      .o_is_sw (w_fd_is_sw)
   );

   assign w_dx_opcode = bus.DX_IR[OPC_MSB:OPC_LSB];
   assign w_dx_rd     = bus.DX_IR[RD_MSB:RD_LSB];
   assign w_dx_alu_op = bus.DX_IR[ALU_MSB:ALU_LSB];
   assign w_unused_dx = ^{bus.DX_IR[RS_MSB:ALU_MSB+1], bus.DX_IR[ALU_LSB-1:0]};

   assign w_dx_is_mul = (w_dx_opcode == OP_RTYPE) && (w_dx_alu_op == ALU_MUL);
   assign w_dx_is_div = (w_dx_opcode == OP_RTYPE) && (w_dx_alu_op == ALU_DIV);
   assign w_dx_is_md  = w_dx_is_mul || w_dx_is_div;
   assign w_dx_is_lw  = (w_dx_opcode == OP_LW) && (w_dx_rd != '0);

   assign w_match_a = w_use_a && (w_src_a == w_dx_rd);
   assign w_match_b = w_use_b && (w_src_b == w_dx_rd);
   // A sw whose only dependency is its data register gets it from the MW-to-dmem bypass.
   assign w_load_use = w_dx_is_lw && (w_match_a || (w_match_b && !w_fd_is_sw));

   always_comb begin
      w_next_state    = r_state;
      w_pc_en         = 1'b1;
      w_fd_en         = 1'b1;
      w_dx_en         = 1'b1;
      w_dx_bubble     = 1'b0;
      w_xm_bubble     = 1'b0;
      w_ctrl_mult     = 1'b0;
      w_ctrl_div      = 1'b0;
      w_md_result_sel = 1'b0;
      w_md_exception  = 1'b0;
      w_md_timeout    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_dx_is_md) begin
               w_next_state = ST_MD_BUSY;
               w_ctrl_mult  = w_dx_is_mul;
               w_ctrl_div   = w_dx_is_div;
               w_pc_en      = 1'b0;
               w_fd_en      = 1'b0;
               w_dx_en      = 1'b0;
               w_xm_bubble  = 1'b1;
            end else if (w_load_use) begin
               w_pc_en     = 1'b0;
               w_fd_en     = 1'b0;
               w_dx_bubble = 1'b1;
            end
         end
         ST_MD_BUSY: begin
            if (bus.multdiv_ready) begin
               w_next_state    = ST_IDLE;
               w_md_result_sel = 1'b1;
               w_md_exception  = bus.multdiv_exception;
            end else if (r_busy_cnt == TIMEOUT_CNT) begin
               w_next_state   = ST_IDLE;
               w_md_timeout   = 1'b1;
               w_md_exception = 1'b1;
            end else begin
               w_pc_en     = 1'b0;
               w_fd_en     = 1'b0;
               w_dx_en     = 1'b0;
               w_xm_bubble = 1'b1;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_busy_cnt    <= '0;
         r_stall_count <= '0;
      end else begin
         // NOTE: non-blocking assignments, so every register samples pre-edge values.
         r_state <= w_next_state;
         // Held at zero in IDLE, which clears it on entry to MD_BUSY.
         if (r_state == ST_MD_BUSY) r_busy_cnt <= r_busy_cnt + BUSY_CNT_W'(1);
         else                       r_busy_cnt <= '0;
         if (!w_pc_en && (r_stall_count != '1)) r_stall_count <= r_stall_count + 32'd1;
      end
   end

   assign bus.pc_en         = w_pc_en;
   assign bus.fd_en         = w_fd_en;
   assign bus.dx_en         = w_dx_en;
   assign bus.dx_bubble     = w_dx_bubble;
   assign bus.xm_bubble     = w_xm_bubble;
   assign bus.ctrl_mult     = w_ctrl_mult;
   assign bus.ctrl_div      = w_ctrl_div;
   assign bus.md_result_sel = w_md_result_sel;
   assign bus.md_exception  = w_md_exception;
   assign bus.md_timeout    = w_md_timeout;
   assign bus.stall_count   = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_control.sv
// Directed bench for hazard_stall_control: each step drives the IRs, queues the
// expected outputs, and compares them against the DUT on the following falling edge.
module tb_hazard_stall_control;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   hazard_stall_control_if bus ();

   hazard_stall_control #(.TIMEOUT(63)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string       tag;
      logic [9:0]  ctl;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks  = 0;
   int          n_pass    = 0;
   logic [31:0] model_cnt = 32'd0;

   // {pc_en, fd_en, dx_en, dx_bubble, xm_bubble, ctrl_mult, ctrl_div, md_result_sel, md_exception, md_timeout}
   localparam logic [9:0] RUN       = 10'b111_00_00_000;
   localparam logic [9:0] LU        = 10'b001_10_00_000;
   localparam logic [9:0] MUL_START = 10'b000_01_10_000;
   localparam logic [9:0] DIV_START = 10'b000_01_01_000;
   localparam logic [9:0] MD_WAIT   = 10'b000_01_00_000;
   localparam logic [9:0] MD_DONE   = 10'b111_00_00_100;
   localparam logic [9:0] MD_DONE_X = 10'b111_00_00_110;
   localparam logic [9:0] MD_TO     = 10'b111_00_00_011;

   localparam logic [31:0] NOP = 32'h0000_0000;

   function automatic logic [31:0] mk_r(input logic [4:0] alu, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
      return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
   endfunction

   function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs);
      return {op, rd, rs, 17'd4};
   endfunction

   function automatic logic [9:0] obs_ctl();
      return {bus.pc_en, bus.fd_en, bus.dx_en, bus.dx_bubble, bus.xm_bubble,
              bus.ctrl_mult, bus.ctrl_div, bus.md_result_sel, bus.md_exception,
              bus.md_timeout};
   endfunction

   task automatic check_out();
      exp_t        e;
      logic [9:0]  ctl;
      logic [31:0] cnt;
      e   = sb_q.pop_front();
      ctl = obs_ctl();
      cnt = bus.stall_count;
      n_checks++;
      assert (ctl === e.ctl) n_pass++;
      else $error("FAIL %s ctl: observed %b expected %b", e.tag, ctl, e.ctl);
      n_checks++;
      assert (cnt === e.cnt) n_pass++;
      else $error("FAIL %s stall_count: observed %0d expected %0d", e.tag, cnt, e.cnt);
   endtask

   task automatic step(input string tag, input logic [31:0] fd, input logic [31:0] dx,
                       input logic rdy, input logic exc, input logic [9:0] ctl);
      exp_t e;
      bus.FD_IR             = fd;
      bus.DX_IR             = dx;
      bus.multdiv_ready     = rdy;
      bus.multdiv_exception = exc;
      e.tag = tag;
      e.ctl = ctl;
      e.cnt = model_cnt;
      sb_q.push_back(e);
      @(negedge clock);
      check_out();
      if (!ctl[9] && (model_cnt != 32'hFFFF_FFFF)) model_cnt++;
      @(posedge clock);
      #1;
   endtask

   logic [31:0] add_6_5_2, mul_ir, div_ir, lw5, lw0, lw7;

   initial begin
      add_6_5_2 = mk_r(5'b00000, 5'd6, 5'd5, 5'd2);
      mul_ir    = mk_r(5'b00110, 5'd4, 5'd1, 5'd2);
      div_ir    = mk_r(5'b00111, 5'd9, 5'd1, 5'd2);
      lw5       = mk_i(5'b01000, 5'd5, 5'd3);
      lw0       = mk_i(5'b01000, 5'd0, 5'd3);
      lw7       = mk_i(5'b01000, 5'd7, 5'd3);

      reset                 = 1'b0;
      bus.FD_IR             = NOP;
      bus.DX_IR             = NOP;
      bus.multdiv_ready     = 1'b0;
      bus.multdiv_exception = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;

      // Reset state and normal flow
      step("reset_idle", NOP, NOP, 1'b0, 1'b0, RUN);

      // Load-use: single bubble, then normal flow
      step("lu_add", add_6_5_2, lw5, 1'b0, 1'b0, LU);
      step("lu_add_after", add_6_5_2, NOP, 1'b0, 1'b0, RUN);

      // sw data-register-only match is bypassed; base-register match stalls
      step("sw_data_only", mk_i(5'b00111, 5'd5, 5'd3), lw5, 1'b0, 1'b0, RUN);
      step("sw_base", mk_i(5'b00111, 5'd2, 5'd5), lw5, 1'b0, 1'b0, LU);
      step("sw_base_after", mk_i(5'b00111, 5'd2, 5'd5), NOP, 1'b0, 1'b0, RUN);
      step("sw_both", mk_i(5'b00111, 5'd7, 5'd7), lw7, 1'b0, 1'b0, LU);

      // Register 0 and per-opcode source sets
      step("lw_r0", mk_r(5'b00000, 5'd1, 5'd0, 5'd0), lw0, 1'b0, 1'b0, RUN);
      step("jr_rd", mk_i(5'b00100, 5'd7, 5'd0), lw7, 1'b0, 1'b0, LU);
      step("bne_rd", mk_i(5'b00010, 5'd7, 5'd1), lw7, 1'b0, 1'b0, LU);
      step("blt_rs", mk_i(5'b00110, 5'd1, 5'd7), lw7, 1'b0, 1'b0, LU);
      step("addi_rs", mk_i(5'b00101, 5'd8, 5'd7), lw7, 1'b0, 1'b0, LU);
      step("addi_rd_only", mk_i(5'b00101, 5'd7, 5'd1), lw7, 1'b0, 1'b0, RUN);
      step("rtype_rt", mk_r(5'b00000, 5'd1, 5'd2, 5'd7), lw7, 1'b0, 1'b0, LU);
      step("other_op", mk_i(5'b00001, 5'd7, 5'd7), lw7, 1'b0, 1'b0, RUN);

      // multdiv_ready outside a handshake is ignored
      step("ready_idle", NOP, NOP, 1'b1, 1'b1, RUN);

      // mul, ready 33 cycles after start
      step("mul_start", add_6_5_2, mul_ir, 1'b0, 1'b0, MUL_START);
      for (int i = 0; i < 32; i++) step("mul_wait", add_6_5_2, mul_ir, 1'b0, 1'b0, MD_WAIT);
      step("mul_done", add_6_5_2, mul_ir, 1'b1, 1'b0, MD_DONE);

      // Back-to-back div with exception, fresh handshake
      step("div_start", add_6_5_2, div_ir, 1'b0, 1'b0, DIV_START);
      for (int i = 0; i < 32; i++) step("div_wait", add_6_5_2, div_ir, 1'b0, 1'b0, MD_WAIT);
      step("div_done_exc", add_6_5_2, div_ir, 1'b1, 1'b1, MD_DONE_X);
      step("after_div", NOP, NOP, 1'b0, 1'b0, RUN);

      // Timeout: 63 busy stall cycles, abort on the next
      step("to_start", NOP, mul_ir, 1'b0, 1'b0, MUL_START);
      for (int i = 0; i < 63; i++) step("to_wait", NOP, mul_ir, 1'b0, 1'b0, MD_WAIT);
      step("to_abort", NOP, mul_ir, 1'b0, 1'b0, MD_TO);
      step("after_to", NOP, NOP, 1'b0, 1'b0, RUN);

      // Reset in the middle of MD_BUSY
      step("rst_mul_start", NOP, mul_ir, 1'b0, 1'b0, MUL_START);
      for (int i = 0; i < 5; i++) step("rst_mul_wait", NOP, mul_ir, 1'b0, 1'b0, MD_WAIT);
      reset     = 1'b0;
      model_cnt = 32'd0;
      step("rst_mid_busy", NOP, NOP, 1'b0, 1'b0, RUN);
      reset = 1'b1;
      step("rst_ready_ignored", NOP, NOP, 1'b1, 1'b0, RUN);
      step("rst_restart", NOP, mul_ir, 1'b0, 1'b0, MUL_START);
      step("rst_restart_wait", NOP, mul_ir, 1'b0, 1'b0, MD_WAIT);
      step("rst_restart_done", NOP, mul_ir, 1'b1, 1'b0, MD_DONE);
      step("final_idle", NOP, NOP, 1'b0, 1'b0, RUN);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hazard_stall_control.md
# hazard_stall_control

Stall and bubble controller for the 5-stage pipeline; the counterpart to forwarding for every hazard that bypass muxes cannot resolve. Detects load-use hazards between FD and DX, runs the start/wait handshake with the multi-cycle multdiv unit, and drives pipeline-latch enables and bubble (nop) insertion. Sits beside the bypass logic, reading the same FD/DX instruction registers, and feeds enables to the PC, FD, DX and XM latches.

## Interface
- TIMEOUT, default 63: cycles in MD_BUSY before a forced abort; 6-bit busy counter.
- clock  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low
- FD_IR  in  32  instruction in the FD latch
- DX_IR  in  32  instruction in the DX latch
- multdiv_ready  in  1  multdiv result valid, single-cycle pulse
- multdiv_exception  in  1  qualified by multdiv_ready
- pc_en, fd_en, dx_en  out  1 each  latch write enables
- dx_bubble  out  1  DX loads nop instead of FD contents
- xm_bubble  out  1  XM loads nop instead of ALU result
- ctrl_mult, ctrl_div  out  1 each  multdiv start pulses
- md_result_sel  out  1  XM O-register takes multdiv result
- md_exception  out  1  write rstatus for the mul/div in DX
- md_timeout  out  1  one-cycle pulse on forced abort
- stall_count  out  32  saturating count of stalled cycles

## Operation
- Fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2]. Register 0 never creates a hazard.
- FD sources: R-type reads rs, rt; addi and lw read rs; sw reads rs and rd; bne and blt read rd and rs; jr reads rd; all others read nothing.
- Load-use: DX opcode 01000 (lw), DX rd != 0, DX rd equals an FD source. Exception: FD is sw (00111), the only match is the sw data register rd, and rs does not match. This case is covered by the MW-to-dmem bypass, so no stall.
- On load-use: pc_en=0, fd_en=0, dx_bubble=1, dx_en=1. Exactly one bubble per hazard.
- mul/div: DX opcode 00000 with ALU op 00110 (mul) or 00111 (div).
- FSM states:
  - IDLE -> MD_BUSY when DX holds mul/div. In that cycle, pulse ctrl_mult or ctrl_div for one cycle and stall.
  - MD_BUSY -> IDLE on multdiv_ready, or when the busy counter reaches TIMEOUT. Stall every cycle except the exit cycle.
- Stall while in MD_BUSY, or in IDLE with mul/div in DX: pc_en=fd_en=dx_en=0, xm_bubble=1, dx_bubble=0.
- Exit on multdiv_ready: all enables 1, md_result_sel=1, md_exception=multdiv_exception. DX advances and the mul/div retires into XM.
- Exit on timeout: md_timeout=1 and md_exception=1. DX advances carrying an undefined result.
- Priority: a multdiv stall masks load-use detection. Load-use is evaluated only in IDLE with no mul/div in DX.
- stall_count increments in every cycle with pc_en=0 and saturates at 32'hFFFFFFFF.
- multdiv_ready is ignored in IDLE.

## Timing
- All enable, bubble and select outputs are combinational from state and the IRs, valid in the same cycle.
- State, busy counter and stall_count are registered.
- Reset (asserted low, any time, including mid-MD_BUSY): state=IDLE, busy counter=0, stall_count=0. Immediately after reset, outputs follow IDLE decode. With nop IRs: pc_en=fd_en=dx_en=1 and all other outputs 0.
- mul/div latency: a start at cycle t with ready at t+k releases the pipeline at t+k. The total stall is k cycles.
- Back-to-back mul/div: the second instruction enters DX at t+k+1 and starts a fresh handshake. It is never skipped or double-started.
- Busy counter clears on entry to MD_BUSY and increments each MD_BUSY cycle.

## Structure
- Shared package holds the opcode constants (OP_RTYPE, OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT, OP_JR), ALU op constants (ALU_MUL, ALU_DIV), instruction field bit positions, and the FSM state encoding.
- One sub-module: hazard_src_decode. It maps an instruction to its source register numbers and use flags. It is instantiated once for FD.

## Test plan
- DX=lw $5, FD=add $6,$5,$2 -> one cycle of pc_en=fd_en=0, dx_bubble=1; normal flow on the next cycle; stall_count=1.
- DX=lw $5, FD=sw $5,0($3) -> no stall. With FD=sw $2,0($5) instead -> one bubble.
- DX=lw $0, FD=add $1,$0,$0 -> no stall.
- DX=mul, ready pulsed 33 cycles later -> ctrl_mult high for exactly one cycle; 33 stall cycles with xm_bubble=1; md_result_sel=1 on the ready cycle. Repeat with div and multdiv_exception=1 -> md_exception=1.
- mul with ready never asserted, TIMEOUT=63 -> md_timeout pulse after 63 busy cycles; pipeline released.
- reset driven low mid-MD_BUSY, then a later ready -> state IDLE, stall_count=0, and the later ready is ignored.
